// File: rtl/fpmul_bus_master.sv
// Bus initiator for the four-word floating-point multiplier register window.
// It writes both operands and the start bit, then polls the status word until
// Done (or until the poll budget runs out). After that it reads the product,
// clears the start bit and hands the product and flags back to the client.
module fpmul_bus_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_p,
    output logic [6:0]  rsp_flags,
    output logic        busy,
    output logic [1:0]  A,
    output logic        WE,
    output logic [31:0] WD,
    input  logic [31:0] RD
);

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_GO,
        POLL,
        RD_P,
        WR_CLR,
        RSP
    } state_t;

    localparam logic [15:0] LAST_POLL = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [15:0] poll_cnt;
    logic        last_poll;

    assign last_poll = (poll_cnt == LAST_POLL);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RSP);

    // State register; reset abandons any in-flight slave transaction.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and bus drive. The bus outputs depend only on the state and the latched operands.
    always_comb begin
        next_state = state;
        A          = 2'b00;
        WE         = 1'b0;
        WD         = 32'h0000_0000;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = WR_A;
                end
            end
            WR_A: begin
                A          = 2'b00;
                WE         = 1'b1;
                WD         = a_q;
                next_state = WR_B;
            end
            WR_B: begin
                A          = 2'b01;
                WE         = 1'b1;
                WD         = b_q;
                next_state = WR_GO;
            end
            WR_GO: begin
                A          = 2'b11;
                WE         = 1'b1;
                WD         = 32'h0001_0000;
                next_state = POLL;
            end
            POLL: begin
                A = 2'b11;
                if (RD[0]) begin
                    next_state = RD_P;
                end else if (last_poll) begin
                    next_state = WR_CLR;
                end
            end
            RD_P: begin
                A          = 2'b10;
                next_state = WR_CLR;
            end
            WR_CLR: begin
                A          = 2'b11;
                WE         = 1'b1;
                WD         = 32'h0000_0000;
                next_state = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, poll counter and response registers (touched only on Done capture or timeout).
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_q       <= 32'h0000_0000;
            b_q       <= 32'h0000_0000;
            poll_cnt  <= 16'h0000;
            rsp_p     <= 32'h0000_0000;
            rsp_flags <= 7'b000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q <= req_a;
                        b_q <= req_b;
                    end
                end
                WR_GO: begin
                    poll_cnt <= 16'h0000;
                end
                POLL: begin
                    if (RD[0]) begin
                        rsp_flags <= {1'b0, RD[13:8]};
                    end else if (last_poll) begin
                        rsp_flags <= 7'b100_0000;
                        rsp_p     <= 32'h0000_0000;
                    end else begin
                        poll_cnt <= poll_cnt + 16'h0001;
                    end
                end
                RD_P: begin
                    rsp_p <= RD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_bus_master.sv
// Self-checking bench for fpmul_bus_master with a behavioural multiplier slave.
module tb_fpmul_bus_master;

    localparam int TO_N = 8;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_p;
    logic [6:0]  rsp_flags;
    logic        busy;
    logic [1:0]  A;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs, set by the test before each request.
    int          cfg_delay = 0;
    bit          cfg_never = 1'b0;
    logic [31:0] cfg_result = 32'h0;
    logic [5:0]  cfg_flags = 6'h0;

    logic [31:0] slv_a;
    logic [31:0] slv_b;
    logic        slv_start;
    logic        slv_armed;
    int          slv_cnt;
    logic        slv_done;

    logic [33:0] wlog[$];
    int          sreads = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          delay;
        bit          never;
        logic [31:0] result;
        logic [5:0]  sflags;
        int          hold;
        logic [31:0] exp_p;
        logic [6:0]  exp_flags;
        int          exp_lat;
        int          exp_reads;
    } vec_t;

    vec_t vecs[10];

    fpmul_bus_master #(.TIMEOUT(TO_N)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_flags (rsp_flags),
        .busy      (busy),
        .A         (A),
        .WE        (WE),
        .WD        (WD),
        .RD        (RD)
    );

    // Free-running clock.
    always #5 Clk = ~Clk;

    initial begin
        slv_a     = 32'h0;
        slv_b     = 32'h0;
        slv_start = 1'b0;
        slv_armed = 1'b0;
        slv_cnt   = 0;
    end

    // Slave register block: a start write arms a Done countdown of cfg_delay cycles.
    always @(posedge Clk) begin
        if (WE) begin
            case (A)
                2'b00: slv_a <= WD;
                2'b01: slv_b <= WD;
                2'b11: begin
                    slv_start <= WD[16];
                    if (WD[16]) begin
                        slv_armed <= 1'b1;
                        slv_cnt   <= cfg_delay;
                    end
                end
                default: ;
            endcase
        end else if (slv_armed && slv_cnt > 0) begin
            slv_cnt <= slv_cnt - 1;
        end
    end

    assign slv_done = slv_armed && (slv_cnt == 0) && !cfg_never;

    // Combinational read port of the slave.
    always_comb begin
        RD = 32'h0;
        case (A)
            2'b00: RD = slv_a;
            2'b01: RD = slv_b;
            2'b10: RD = cfg_result;
            2'b11: RD = {15'b0, slv_start, 2'b00, cfg_flags, 7'b0, slv_done};
            default: RD = 32'h0;
        endcase
    end

    // Bus monitor: logs every write and counts status reads.
    always @(posedge Clk) begin
        if (!Rst) begin
            if (WE) wlog.push_back({A, WD});
            if (A == 2'b11 && !WE) sreads++;
        end
    end

    // Reference model: Done is seen on poll number delay, unless the budget runs out first.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (!v.never && v.delay < TO_N) begin
            r.exp_p     = v.result;
            r.exp_flags = {1'b0, v.sflags};
            r.exp_lat   = 4 + v.delay + 3;
            r.exp_reads = v.delay + 1;
        end else begin
            r.exp_p     = 32'h0;
            r.exp_flags = 7'b100_0000;
            r.exp_lat   = 4 + (TO_N - 1) + 2;
            r.exp_reads = TO_N;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkWrites(input int base, input logic [31:0] a, input logic [31:0] b);
        logic [33:0] exp_w[4];
        exp_w[0] = {2'b00, a};
        exp_w[1] = {2'b01, b};
        exp_w[2] = {2'b11, 32'h0001_0000};
        exp_w[3] = {2'b11, 32'h0000_0000};
        checkOutput("write_count", 32'(wlog.size() - base), 32'd4);
        if (wlog.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("wr%0d_addr", i), 32'(wlog[base + i][33:32]), 32'(exp_w[i][33:32]));
                checkOutput($sformatf("wr%0d_data", i), wlog[base + i][31:0], exp_w[i][31:0]);
            end
        end
    endtask

    // Runs one full request/response transaction from IDLE and checks it against the vector.
    task automatic applyStimulus(input vec_t v);
        int          base_w;
        int          base_r;
        int          cyc;
        logic [31:0] p0;
        logic [6:0]  f0;
        cfg_delay  = v.delay;
        cfg_never  = v.never;
        cfg_result = v.result;
        cfg_flags  = v.sflags;
        @(negedge Clk);
        base_w    = wlog.size();
        base_r    = sreads;
        req_a     = v.a;
        req_b     = v.b;
        req_valid = 1'b1;
        rsp_ready = (v.hold == 0);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge Clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while (1) begin
            @(negedge Clk);
            cyc++;
            if (rsp_valid || cyc >= 200) break;
        end
        checkOutput("rsp_latency", 32'(cyc), 32'(v.exp_lat));
        checkOutput("rsp_p", rsp_p, v.exp_p);
        checkOutput("rsp_flags", 32'(rsp_flags), 32'(v.exp_flags));
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        checkOutput("busy_rsp", 32'(busy), 32'd1);
        p0 = rsp_p;
        f0 = rsp_flags;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge Clk);
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_p", rsp_p, p0);
            checkOutput("hold_flags", 32'(rsp_flags), 32'(f0));
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
            checkOutput("hold_no_writes", 32'(wlog.size() - base_w), 32'd4);
        end
        rsp_ready = 1'b1;
        @(negedge Clk);
        checkOutput("post_hs_valid", 32'(rsp_valid), 32'd0);
        checkOutput("post_hs_ready", 32'(req_ready), 32'd1);
        checkOutput("status_reads", 32'(sreads - base_r), 32'(v.exp_reads));
        checkWrites(base_w, v.a, v.b);
    endtask

    initial begin
        int          cyc;
        int          base_w;
        vec_t        v;
        Rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b1;

        // Directed entries with hand-derived expectations.
        vecs[0] = '{32'h3FC0_0000, 32'h4000_0000, 4, 1'b0, 32'h4040_0000, 6'h00, 0,
                    32'h4040_0000, 7'b000_0000, 11, 5};
        vecs[1] = '{32'h7F00_0000, 32'h7F00_0000, 2, 1'b0, 32'h7F80_0000, 6'b100100, 0,
                    32'h7F80_0000, 7'b010_0100, 9, 3};
        vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b1, 32'hDEAD_BEEF, 6'h3F, 0,
                    32'h0, 7'b100_0000, 13, 8};
        vecs[3] = '{32'h3F80_0000, 32'h4040_0000, 1, 1'b0, 32'h4040_0000, 6'h00, 5,
                    32'h4040_0000, 7'b000_0000, 8, 2};
        for (int i = 4; i < 10; i++) begin
            v.a      = $urandom;
            v.b      = $urandom;
            v.delay  = $urandom_range(0, 9);
            v.never  = ($urandom_range(0, 5) == 0);
            v.result = $urandom;
            v.sflags = 6'($urandom);
            v.hold   = $urandom_range(0, 2);
            vecs[i]  = model(v);
        end

        repeat (2) @(negedge Clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_bus", {WE, A, 29'(WD)}, 32'd0);
        checkOutput("reset_rsp", {25'(rsp_p), rsp_flags}, 32'd0);
        Rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of polling must drop every output at once.
        cfg_delay = 10;
        cfg_never = 1'b0;
        cfg_result = 32'h5555_AAAA;
        cfg_flags = 6'h00;
        @(negedge Clk);
        req_a     = 32'h4000_0000;
        req_b     = 32'h4000_0000;
        req_valid = 1'b1;
        @(posedge Clk);
        #1 req_valid = 1'b0;
        repeat (6) @(negedge Clk);
        checkOutput("mid_poll_addr", 32'(A), 32'd3);
        #2 Rst = 1'b1;
        #1;
        checkOutput("async_req_ready", 32'(req_ready), 32'd1);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("async_bus", {WE, A, 29'(WD)}, 32'd0);
        checkOutput("async_rsp", {25'(rsp_p), rsp_flags}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        v = '{32'h4000_0000, 32'h4040_0000, 3, 1'b0, 32'h40C0_0000, 6'h00, 0,
              32'h40C0_0000, 7'b000_0000, 10, 4};
        applyStimulus(v);

        // Back-to-back requests with req_valid held high.
        cfg_delay  = 1;
        cfg_never  = 1'b0;
        cfg_result = 32'h4110_0000;
        cfg_flags  = 6'h00;
        rsp_ready  = 1'b1;
        @(negedge Clk);
        req_a     = 32'h4040_0000;
        req_b     = 32'h4040_0000;
        req_valid = 1'b1;
        @(posedge Clk);
        #1;
        req_a = 32'h4080_0000;
        req_b = 32'h3F00_0000;
        cyc = 0;
        while (1) begin
            @(negedge Clk);
            cyc++;
            if (rsp_valid || cyc >= 200) break;
        end
        checkOutput("b2b_first_lat", 32'(cyc), 32'd8);
        checkOutput("b2b_first_p", rsp_p, 32'h4110_0000);
        base_w = wlog.size();
        @(negedge Clk);
        checkOutput("b2b_idle_ready", 32'(req_ready), 32'd1);
        cfg_result = 32'h4000_0000;
        @(negedge Clk);
        checkOutput("b2b_accept_we", 32'(WE), 32'd1);
        checkOutput("b2b_accept_addr", 32'(A), 32'd0);
        checkOutput("b2b_accept_wd", WD, 32'h4080_0000);
        req_valid = 1'b0;
        cyc = 1;
        while (1) begin
            @(negedge Clk);
            cyc++;
            if (rsp_valid || cyc >= 200) break;
        end
        checkOutput("b2b_second_lat", 32'(cyc), 32'd8);
        checkOutput("b2b_second_p", rsp_p, 32'h4000_0000);
        @(negedge Clk);
        checkWrites(base_w, 32'h4080_0000, 32'h3F00_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpmul_bus_master.md
# fpmul_bus_master

Bus initiator that drives the four-word floating-point multiplier register window: address bits A[1:0], write enable, write data, and combinational read data. It takes an operand pair over a valid/ready request port and writes OpA, then OpB, then the start bit. It polls the status word until done, reads the product, clears the start bit, and returns the product and flags over a valid/ready response port. It sits between a compute client (sequencer or CPU-side FIFO) and the multiplier register block, so the client never handles the register map directly.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of status polls before aborting; legal range 1..65535.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  32  operand A (IEEE-754 single).
- req_b  in  32  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  client accepts the response.
- rsp_p  out  32  product; 0 on timeout.
- rsp_flags  out  7  {TO, OF, UF, NANF, INFF, DNF, ZF}.
- busy  out  1  high in every state except IDLE.
- A  out  2  register address: 00 OpA, 01 OpB, 10 result, 11 control/status.
- WE  out  1  write strobe; the slave writes on the Clk edge where WE=1.
- WD  out  32  write data.
- RD  in  32  read data; combinational from A, sampled in the same cycle.

## Operation
Status word layout (A=11 read):
- bit0: Done.
- bit8: ZF. bit9: DNF. bit10: INFF. bit11: NANF. bit12: UF. bit13: OF.
- bit16: Start.
- All other bits read 0.

Control write (A=11): bit16=1 starts an operation and clears Done. A write of 0 clears Start without starting.

FSM states and transitions:
- IDLE: req_ready=1. On req_valid, latch req_a and req_b, then go to WR_A.
- WR_A: A=00, WE=1, WD=a. Go to WR_B.
- WR_B: A=01, WE=1, WD=b. Go to WR_GO.
- WR_GO: A=11, WE=1, WD=32'h0001_0000. Clear the poll counter. Go to POLL.
- POLL: A=11, WE=0.
  - If RD[0]=1: capture RD[13:8] into flags[5:0], set TO=0, go to RD_P.
  - Else if the poll counter equals TIMEOUT-1: set TO=1, flags[5:0]=0, result=0, go to WR_CLR.
  - Else: increment the poll counter and stay in POLL.
- RD_P: A=10, WE=0, capture RD into the result. Go to WR_CLR.
- WR_CLR: A=11, WE=1, WD=0. Go to RSP.
- RSP: rsp_valid=1. rsp_p and rsp_flags are held stable until rsp_ready=1, then go to IDLE.

Rules:
- Outside the write states: WE=0, WD=0, A=00 in IDLE.
- The poll counter is 16 bits.
- The response registers change only on a Done capture, on a timeout, or on reset.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_p=0, rsp_flags=0, busy=0, A=00, WE=0, WD=0, FSM in IDLE, poll counter 0.
- A, WE, WD and rsp_* are registered or decoded from state only. Nothing combinational passes from RD or rsp_ready to the bus outputs.
- Request accepted at edge 0. Bus writes occur at cycles 1, 2 and 3. The first poll is cycle 4.
- If Done is first seen at poll cycle k, RD_P is k+1, WR_CLR is k+2, and rsp_valid rises at k+3.
- Minimum request-to-rsp_valid latency is 7 cycles.
- Timeout: TIMEOUT polls are performed. rsp_valid rises 2 cycles after the last poll, with TO=1.
- req_ready=0 from the accept edge until the RSP handshake completes. After the handshake, IDLE is re-entered and req_ready=1 on the next cycle; there is no pipelining of requests.
- rsp_ready held high: RSP lasts one cycle.
- The Done bit is cleared by the WR_GO write, so a stale Done from a prior operation is never seen in POLL.
- Rst asserted mid-operation: all outputs return to their reset values immediately, without waiting for the clock.
  - An in-flight slave operation is abandoned. The slave's Start bit may remain set.
  - The next operation's WR_GO restarts the slave correctly.

## Test plan
- Basic multiply: req_a=3FC00000, req_b=40000000, with a slave model that sets Done 4 cycles after start. Required:
  - bus writes (00,3FC00000), (01,40000000), (11,00010000), then later (11,0);
  - rsp_p=40400000, rsp_flags=0, rsp_valid at cycle 11.
- Flags: slave returns status 0x0000_2401 with result 7F800000. Required: rsp_flags=7'b0100100 (OF and INFF set), rsp_p=7F800000.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. Required:
  - rsp_valid, rsp_p and rsp_flags stay stable;
  - req_ready=0 throughout and no bus writes occur;
  - the handshake completes on the cycle rsp_ready rises.
- Timeout: TIMEOUT=8 and a slave that never sets Done. Required:
  - exactly 8 status reads, then the clear write;
  - rsp_flags=7'b1000000, rsp_p=0.
- Reset mid-poll: assert Rst in cycle 6. Required:
  - all outputs take their reset values asynchronously;
  - a new request after reset completes normally with the correct product.
- Back-to-back: two requests with req_valid held high. Required: the second request is accepted exactly 1 cycle after the first response handshake, and its bus sequence repeats the basic pattern.
